// File: rtl/rsa_pkg.sv
// Shared RSA key-generation definitions: default operand widths and the create_d state encoding.
package rsa_pkg;
  localparam int RSA_W   = 64;
  localparam int RSA_CW  = 7;
  localparam int RSA_L_W = RSA_W;
  localparam int RSA_E_W = RSA_W;
  localparam int RSA_D_W = RSA_W;

  typedef enum logic [3:0] {
    S_IDLE, S_CHECK, S_DIV, S_MUL, S_UPD, S_FIN, S_FAIL, S_DONE, S_VERIFY
  } create_d_state_t;
endpackage

// File: rtl/divmod_seq.sv
// W-bit restoring divider, one quotient bit per clock. The go cycle performs the first
// step on the live inputs, so q/rem are final after exactly W edges and done pulses then.
module divmod_seq
  import rsa_pkg::*;
#(
  parameter int W  = RSA_W,
  parameter int CW = RSA_CW
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         go,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] q,
  output logic [W-1:0] rem,
  output logic         done
);
  logic [W-1:0]  dq, rm, dv, s_dq, s_rm, s_dv, n_dq, n_rm;
  logic [W:0]    trial;
  logic [CW-1:0] cnt;

  always_comb begin
    s_dq  = go ? dividend : dq;
    s_rm  = go ? '0 : rm;
    s_dv  = go ? divisor : dv;
    trial = {s_rm, s_dq[W-1]};
    if (trial >= {1'b0, s_dv}) begin
      n_rm = W'(trial - {1'b0, s_dv});
      n_dq = {s_dq[W-2:0], 1'b1};
    end else begin
      n_rm = trial[W-1:0];
      n_dq = {s_dq[W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dq   <= '0;
      rm   <= '0;
      dv   <= '0;
      cnt  <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (go) begin
        dq  <= n_dq;
        rm  <= n_rm;
        dv  <= divisor;
        cnt <= CW'(W - 1);
      end else if (cnt != '0) begin
        dq   <= n_dq;
        rm   <= n_rm;
        cnt  <= cnt - CW'(1);
        done <= (cnt == CW'(1));
      end
    end
  end

  assign q   = dq;
  assign rem = rm;
endmodule

// File: rtl/create_d.sv
// Private exponent D = E^-1 mod L by iterative extended Euclid with a serial divider and
// shift-add multiplier. Define CREATE_D_VERIFY_EN to add a serial E*D mod L == 1 self-check.
module create_d
  import rsa_pkg::*;
#(
  parameter int W  = RSA_W,
  parameter int CW = RSA_CW
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] L,
  input  logic [W-1:0] E,
  input  logic         start_n,
  output logic [W-1:0] D,
  output logic         ready_n,
  output logic         err_n,
  output logic         busy
);
  create_d_state_t   state;
  logic [W-1:0]      r0, r1, l_q, mq, d_fin;
  logic signed [W:0] t0, t1, mc, p;
  logic [CW-1:0]     mcnt;
  logic              red;
  logic              go, div_done;
  logic [W-1:0]      dividend, divisor, div_q, div_rem;

  divmod_seq #(.W(W), .CW(CW)) u_div (
    .clk(clk), .rst(rst), .go(go), .dividend(dividend), .divisor(divisor),
    .q(div_q), .rem(div_rem), .done(div_done)
  );

  // Launch the divider on the edge that enters DIV, so DIV occupies exactly W cycles.
  always_comb begin
    go       = 1'b0;
    dividend = r0;
    divisor  = r1;
    case (state)
      S_CHECK: if (!(r0 < W'(2) || r1 == '0)) begin
        go = 1'b1;
        if (r1 >= r0) begin
          dividend = r1;
          divisor  = r0;
        end
      end
      S_DIV: if (div_done && red && div_rem != '0) begin
        go      = 1'b1;
        divisor = div_rem;
      end
      S_UPD: if (div_rem != '0) begin
        go       = 1'b1;
        dividend = r1;
        divisor  = div_rem;
      end
      default: ;
    endcase
  end

  // Negative t0 lies in (-L, 0); adding L modulo 2^W yields the canonical residue.
  assign d_fin = t0[W-1:0] + (t0[W] ? l_q : '0);

`ifdef CREATE_D_VERIFY_EN
  logic [W-1:0]  e_red, vacc, vb, va_n;
  logic [W+1:0]  a2, l2;
  logic [CW-1:0] vcnt;

  // Interleaved modmul: acc = 2*acc + bit*e stays below 3L, so at most one of two subtractions.
  always_comb begin
    a2 = {1'b0, vacc, 1'b0} + (vb[W-1] ? {2'b0, e_red} : '0);
    l2 = {1'b0, l_q, 1'b0};
    if (a2 >= l2)                va_n = W'(a2 - l2);
    else if (a2 >= {2'b0, l_q})  va_n = W'(a2 - {2'b0, l_q});
    else                         va_n = W'(a2);
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      D       <= '0;
      ready_n <= 1'b1;
      err_n   <= 1'b1;
      busy    <= 1'b0;
      r0      <= '0;
      r1      <= '0;
      l_q     <= '0;
      t0      <= '0;
      t1      <= '0;
      mc      <= '0;
      p       <= '0;
      mq      <= '0;
      mcnt    <= '0;
      red     <= 1'b0;
`ifdef CREATE_D_VERIFY_EN
      e_red   <= '0;
      vacc    <= '0;
      vb      <= '0;
      vcnt    <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: if (!start_n) begin
          l_q     <= L;
          r0      <= L;
          r1      <= E;
          t0      <= '0;
          t1      <= {{W{1'b0}}, 1'b1};
          red     <= 1'b0;
          busy    <= 1'b1;
          ready_n <= 1'b1;
          err_n   <= 1'b1;
          state   <= S_CHECK;
        end
        S_CHECK: begin
          if (r0 < W'(2) || r1 == '0) state <= S_FAIL;
          else begin
            red   <= (r1 >= r0);
            state <= S_DIV;
`ifdef CREATE_D_VERIFY_EN
            e_red <= r1;
`endif
          end
        end
        S_DIV: if (div_done) begin
          if (red) begin
            // E mod L is done; the first Euclid division was already launched above.
            red   <= 1'b0;
            r1    <= div_rem;
            state <= (div_rem == '0) ? S_FAIL : S_DIV;
`ifdef CREATE_D_VERIFY_EN
            e_red <= div_rem;
`endif
          end else begin
            mc    <= t1;
            mq    <= div_q;
            p     <= '0;
            mcnt  <= CW'(W);
            state <= S_MUL;
          end
        end
        S_MUL: begin
          if (mq[0]) p <= p + mc;
          mc   <= mc <<< 1;
          mq   <= mq >> 1;
          mcnt <= mcnt - CW'(1);
          if (mcnt == CW'(1)) state <= S_UPD;
        end
        S_UPD: begin
          r0    <= r1;
          r1    <= div_rem;
          t0    <= t1;
          t1    <= t0 - p;
          state <= (div_rem == '0) ? S_FIN : S_DIV;
        end
        S_FIN: begin
          if (r0 != W'(1)) state <= S_FAIL;
          else begin
            D     <= d_fin;
`ifdef CREATE_D_VERIFY_EN
            vacc  <= '0;
            vb    <= d_fin;
            vcnt  <= CW'(W);
            state <= S_VERIFY;
`else
            state <= S_DONE;
`endif
          end
        end
`ifdef CREATE_D_VERIFY_EN
        S_VERIFY: begin
          vacc <= va_n;
          vb   <= vb << 1;
          vcnt <= vcnt - CW'(1);
          if (vcnt == CW'(1)) begin
            if (va_n != W'(1)) begin
              D     <= '0;
              err_n <= 1'b0;
            end
            state <= S_DONE;
          end
        end
`endif
        S_FAIL: begin
          D     <= '0;
          err_n <= 1'b0;
          state <= S_DONE;
        end
        S_DONE: begin
          ready_n <= 1'b0;
          busy    <= 1'b0;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
